// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I pipeline front end.
package rv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: hazard-unit controls, EX/MEM redirect, instruction memory and IF/ID outputs.
interface fetch_unit_if;
    import rv_pkg::*;

    logic            pc_wren;
    logic            IFID_wren;
    logic            IFID_clear;
    logic            EXMEM_pcsel;
    logic            EXMEM_is_br;
    logic            EXMEM_is_uncbr;
    logic [XLEN-1:0] EXMEM_alu_data;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rden;
    logic [XLEN-1:0] IFID_pc;
    logic [XLEN-1:0] IFID_instr;
    logic            IFID_valid;
    logic [4:0]      IFID_rs1;
    logic [4:0]      IFID_rs2;

    // master is the fetch unit; slave is the surrounding pipeline and memory
    modport master (
        input  pc_wren, IFID_wren, IFID_clear,
        input  EXMEM_pcsel, EXMEM_is_br, EXMEM_is_uncbr, EXMEM_alu_data,
        input  imem_rdata,
        output imem_addr, imem_rden,
        output IFID_pc, IFID_instr, IFID_valid, IFID_rs1, IFID_rs2
    );

    modport slave (
        output pc_wren, IFID_wren, IFID_clear,
        output EXMEM_pcsel, EXMEM_is_br, EXMEM_is_uncbr, EXMEM_alu_data,
        output imem_rdata,
        input  imem_addr, imem_rden,
        input  IFID_pc, IFID_instr, IFID_valid, IFID_rs1, IFID_rs2
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register: owns the PC, reads imem, applies hdu stall/flush and EX/MEM redirects.
module fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     bus,
    output logic             misalign,
    output logic [31:0]      misalign_pc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] next_pc;
    logic            imem_rden;
    logic            redirect;
    logic            bad_target;
    logic            take_halt;
    logic            stall_inc;
    logic            flush_inc;
    logic [XLEN-1:0] ifid_pc_q;
    logic [XLEN-1:0] ifid_instr_q;
    logic            ifid_valid_q;

    assign redirect   = bus.EXMEM_pcsel & (bus.EXMEM_is_br | bus.EXMEM_is_uncbr);
    assign bad_target = (bus.EXMEM_alu_data[1:0] != 2'b00);
    assign take_halt  = (state == RUN) && redirect && bad_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = take_halt ? HALT : RUN;
            HALT:    state_nxt = HALT;
            default: state_nxt = BOOT;
        endcase
    end

    // Stall re-presents pc_q, so imem_rdata always belongs to pc_q and no hold buffer is needed.
    always_comb begin
        next_pc   = pc_q;
        imem_rden = 1'b1;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst) begin
            next_pc = RESET_PC;
        end else begin
            unique case (state)
                BOOT: next_pc = pc_q;
                RUN: begin
                    if (redirect) begin
                        next_pc = bus.EXMEM_alu_data;
                    end else if (bus.pc_wren) begin
                        next_pc = pc_q + 32'd4;
                    end
                    stall_inc = !bus.pc_wren && !redirect;
                    flush_inc = redirect && !bad_target;
                end
                HALT:    imem_rden = 1'b0;
                default: next_pc = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else if (state == RUN && !bus.IFID_clear) begin
            if (bus.IFID_wren) begin
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= bus.imem_rdata;
                ifid_valid_q <= 1'b1;
            end
        end else begin
            // BOOT bubble, HALT, and an explicit clear all load a NOP
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign    <= 1'b0;
            misalign_pc <= '0;
        end else if (take_halt) begin
            misalign    <= 1'b1;
            misalign_pc <= bus.EXMEM_alu_data;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign bus.imem_addr  = next_pc;
    assign bus.imem_rden  = imem_rden;
    assign bus.IFID_pc    = ifid_pc_q;
    assign bus.IFID_instr = ifid_instr_q;
    assign bus.IFID_valid = ifid_valid_q;
    assign bus.IFID_rs1   = ifid_instr_q[19:15];
    assign bus.IFID_rs2   = ifid_instr_q[24:20];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: RESET_PC=0x100, 4-bit counters, synchronous imem model.
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic [31:0] mis_pc;
        logic [3:0]  stall;
        logic [3:0]  flush;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        misalign;
    logic [31:0] misalign_pc;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    int total;
    int bad;

    exp_t         sbq[$];
    exp_t         m_ifid;
    fetch_state_e m_state;
    logic [31:0]  m_pc;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RST_PC),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .misalign    (misalign),
        .misalign_pc (misalign_pc),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[9:2], a[9:2], a[9:2], a[9:2]} | 32'h0000_0013;
    endfunction

    // instruction memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.imem_rden) bus.imem_rdata <= memWord(bus.imem_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic compareAll(input exp_t e);
        checkOutput("ifid_pc", bus.IFID_pc, e.pc);
        checkOutput("ifid_instr", bus.IFID_instr, e.instr);
        checkOutput("ifid_valid", 32'(bus.IFID_valid), 32'(e.valid));
        checkOutput("ifid_rs1", 32'(bus.IFID_rs1), 32'(e.instr[19:15]));
        checkOutput("ifid_rs2", 32'(bus.IFID_rs2), 32'(e.instr[24:20]));
        checkOutput("misalign", 32'(misalign), 32'(e.mis));
        checkOutput("misalign_pc", misalign_pc, e.mis_pc);
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        checkOutput("flush_cnt", 32'(flush_cnt), 32'(e.flush));
    endtask

    task automatic doReset();
        exp_t e;
        rst = 1'b1;
        bus.pc_wren = 1'b0;
        bus.IFID_wren = 1'b0;
        bus.IFID_clear = 1'b0;
        bus.EXMEM_pcsel = 1'b0;
        bus.EXMEM_is_br = 1'b0;
        bus.EXMEM_is_uncbr = 1'b0;
        bus.EXMEM_alu_data = 32'h0;
        #1;
        checkOutput("rst_imem_addr", bus.imem_addr, RST_PC);
        checkOutput("rst_imem_rden", 32'(bus.imem_rden), 32'd1);
        e.pc = 32'h0; e.instr = NOP_INSTR; e.valid = 1'b0;
        e.mis = 1'b0; e.mis_pc = 32'h0; e.stall = 4'h0; e.flush = 4'h0;
        sbq.push_back(e);
        @(posedge clk); #1;
        compareAll(sbq.pop_front());
        m_ifid  = e;
        m_state = BOOT;
        m_pc    = RST_PC;
        rst     = 1'b0;
    endtask

    // f = {pc_wren, IFID_wren, IFID_clear, EXMEM_pcsel, EXMEM_is_br, EXMEM_is_uncbr}
    task automatic applyStimulus(input logic [5:0] f, input logic [31:0] tgt);
        exp_t        e;
        logic        redir;
        logic [31:0] exp_addr;
        logic        exp_rden;
        bus.pc_wren        = f[5];
        bus.IFID_wren      = f[4];
        bus.IFID_clear     = f[3];
        bus.EXMEM_pcsel    = f[2];
        bus.EXMEM_is_br    = f[1];
        bus.EXMEM_is_uncbr = f[0];
        bus.EXMEM_alu_data = tgt;
        #1;
        redir    = f[2] & (f[1] | f[0]);
        exp_addr = m_pc;
        exp_rden = 1'b1;
        e        = m_ifid;
        case (m_state)
            BOOT: begin
                e.pc = 32'h0; e.instr = NOP_INSTR; e.valid = 1'b0;
                m_state = RUN;
            end
            RUN: begin
                if (redir) exp_addr = tgt;
                else if (f[5]) exp_addr = m_pc + 32'd4;
                if (f[3]) begin
                    e.pc = 32'h0; e.instr = NOP_INSTR; e.valid = 1'b0;
                end else if (f[4]) begin
                    e.pc = m_pc; e.instr = memWord(m_pc); e.valid = 1'b1;
                end
                if (redir && tgt[1:0] != 2'b00) begin
                    m_state = HALT; e.mis = 1'b1; e.mis_pc = tgt;
                end else if (redir && e.flush != 4'hF) begin
                    e.flush = e.flush + 4'd1;
                end
                if (!f[5] && !redir && e.stall != 4'hF) e.stall = e.stall + 4'd1;
            end
            default: begin
                exp_rden = 1'b0;
                e.pc = 32'h0; e.instr = NOP_INSTR; e.valid = 1'b0;
            end
        endcase
        checkOutput("imem_addr", bus.imem_addr, exp_addr);
        checkOutput("imem_rden", 32'(bus.imem_rden), 32'(exp_rden));
        sbq.push_back(e);
        m_pc   = exp_addr;
        m_ifid = e;
        @(posedge clk); #1;
        compareAll(sbq.pop_front());
    endtask

    task automatic randomCycle(input logic allow_redirect);
        logic [5:0]  f;
        logic [31:0] tgt;
        f   = 6'($urandom_range(0, 63));
        tgt = 32'($urandom_range(0, 1023)) << 2;
        if (!allow_redirect || $urandom_range(0, 7) != 0) f[2] = 1'b0;
        applyStimulus(f, tgt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        doReset();

        applyStimulus(6'b110000, 32'h0);
        checkOutput("t1_boot_bubble", 32'(bus.IFID_valid), 32'd0);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t1_first_pc", bus.IFID_pc, 32'h100);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t1_second_pc", bus.IFID_pc, 32'h104);

        repeat (3) begin
            applyStimulus(6'b000000, 32'h0);
            checkOutput("t2_held_pc", bus.IFID_pc, 32'h104);
        end
        checkOutput("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t2_resume_pc", bus.IFID_pc, 32'h108);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t2_next_pc", bus.IFID_pc, 32'h10C);

        applyStimulus(6'b111110, 32'h200);
        checkOutput("t3_flush_bubble", 32'(bus.IFID_valid), 32'd0);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t3_target_pc", bus.IFID_pc, 32'h200);
        checkOutput("t3_flush_cnt", 32'(flush_cnt), 32'd1);

        applyStimulus(6'b110100, 32'h300);
        checkOutput("pcsel_no_type", bus.IFID_pc, 32'h204);
        applyStimulus(6'b110011, 32'h300);
        checkOutput("type_no_pcsel", bus.IFID_pc, 32'h208);
        checkOutput("no_redirect_flush", 32'(flush_cnt), 32'd1);

        applyStimulus(6'b001101, 32'h200);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t4_target_pc", bus.IFID_pc, 32'h200);
        checkOutput("t4_flush_cnt", 32'(flush_cnt), 32'd2);
        checkOutput("t4_stall_cnt", 32'(stall_cnt), 32'd3);

        repeat (40) randomCycle(1'b1);

        applyStimulus(6'b111110, 32'h202);
        checkOutput("t5_misalign", 32'(misalign), 32'd1);
        checkOutput("t5_misalign_pc", misalign_pc, 32'h202);
        repeat (10) begin
            randomCycle(1'b1);
            applyStimulus(6'b110111, 32'h400);
            checkOutput("t5_halt_valid", 32'(bus.IFID_valid), 32'd0);
            checkOutput("t5_halt_mis_pc", misalign_pc, 32'h202);
        end
        doReset();
        applyStimulus(6'b110000, 32'h0);
        applyStimulus(6'b110000, 32'h0);
        checkOutput("t5_restart_pc", bus.IFID_pc, RST_PC);

        repeat (20) applyStimulus(6'b000000, 32'h0);
        checkOutput("t6_stall_sat", 32'(stall_cnt), 32'hF);
        repeat (2) applyStimulus(6'b010000, 32'h0);
        checkOutput("t6_stall_stays", 32'(stall_cnt), 32'hF);

        repeat (20) randomCycle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
